// File: rtl/hp_sweep_pkg.sv
// Shared types and constants for the hoggephase trial sequencer.
// Register offsets, CFG field positions, FSM state encoding and a saturating adder.
package hp_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POWER,
    ST_CLEAR,
    ST_GLITCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam logic [31:0] REG_CTRL   = 32'h00;
  localparam logic [31:0] REG_CFG    = 32'h04;
  localparam logic [31:0] REG_STATUS = 32'h08;
  localparam logic [31:0] REG_SUM    = 32'h0C;
  localparam logic [31:0] REG_MAP    = 32'h10;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_ABORT_BIT   = 1;
  localparam int CFG_SETTLE_LSB   = 0;
  localparam int CFG_GLEN_LSB     = 8;
  localparam int CFG_TRIALS_LSB   = 16;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {9'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/hp_sweep_wb_regs.sv
// Wishbone slave for the sweep sequencer: address decode, registered ack/readback,
// CFG storage and START/ABORT command pulses.
module hp_sweep_wb_regs
  import hp_sweep_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_i,
  output logic        ack,
  output logic [31:0] dat_o,
  input  logic        busy,
  input  logic        done,
  input  logic        aborted,
  input  logic [7:0]  trial_cnt,
  input  logic [7:0]  hit_cnt,
  input  logic [15:0] alarm_sum,
  input  logic [31:0] hit_map,
  output logic        start_req,
  output logic        abort_req,
  output logic [7:0]  cfg_settle,
  output logic [7:0]  cfg_glen,
  output logic [7:0]  cfg_trials
);

  logic        sel_ctrl, sel_cfg, sel_status, sel_sum, sel_map;
  logic        req, wr, rd;
  logic [23:0] cfg_q, cfg_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d, rdata;
  logic        unused_dat_hi;

  assign sel_ctrl   = (adr == BASE_ADDRESS + REG_CTRL);
  assign sel_cfg    = (adr == BASE_ADDRESS + REG_CFG);
  assign sel_status = (adr == BASE_ADDRESS + REG_STATUS);
  assign sel_sum    = (adr == BASE_ADDRESS + REG_SUM);
  assign sel_map    = (adr == BASE_ADDRESS + REG_MAP);

  assign req = cyc & stb & (sel_ctrl | sel_cfg | sel_status | sel_sum | sel_map);
  assign wr  = req & we;
  assign rd  = req & ~we;

  // Commands act on the same edge that accepts the write.
  assign start_req = wr & sel_ctrl & dat_i[CTRL_START_BIT];
  assign abort_req = wr & sel_ctrl & dat_i[CTRL_ABORT_BIT];

  assign unused_dat_hi = ^dat_i[31:24];

  always_comb begin
    rdata = '0;
    if (sel_cfg)         rdata = {8'd0, cfg_q};
    else if (sel_status) rdata = {8'd0, hit_cnt, trial_cnt, 5'd0, aborted, done, busy};
    else if (sel_sum)    rdata = {16'd0, alarm_sum};
    else if (sel_map)    rdata = hit_map;
  end

  always_comb begin
    cfg_d = cfg_q;
    if (wr && sel_cfg && !busy) cfg_d = dat_i[23:0];
    ack_d = req;
    dat_d = rd ? rdata : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cfg_q <= '0;
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign ack        = ack_q;
  assign dat_o      = dat_q;
  assign cfg_settle = cfg_q[CFG_SETTLE_LSB +: 8];
  assign cfg_glen   = cfg_q[CFG_GLEN_LSB +: 8];
  assign cfg_trials = cfg_q[CFG_TRIALS_LSB +: 8];

endmodule

// File: rtl/hp_sweep_ctrl.sv
// Trial sequencer for the hoggephase glitch detectors: power, clear, glitch, settle, sample.
// Optional per-trial hit bitmap enabled by defining HP_SWEEP_HITMAP_EN.
module hp_sweep_ctrl
  import hp_sweep_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100
) (
  input  logic        wb_clk_i,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_stl_o,
  output logic [31:0] wbs_dat_o,
  input  logic        hp_alarm_latch,
  input  logic [7:0]  hp_alarm_ctr,
  output logic        hp_vcc,
  output logic        hp_alarm_rst,
  output logic        hp_alarm_ctr_rst,
  output logic        hp_glitch_en,
  output logic        busy,
  output logic        irq
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  trial_cnt_q, trial_cnt_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic [15:0] sum_q, sum_d;
  logic        done_q, done_d, aborted_q, aborted_d;
  logic        vcc_q, vcc_d, rst_q, rst_d, glitch_q, glitch_d;
  logic        irq_q, irq_d, busy_q, busy_d;
  logic        start_req, abort_req;
  logic [7:0]  cfg_settle, cfg_glen, cfg_trials;
  logic        do_start, do_abort, do_sample;
  logic [31:0] hit_map;

  hp_sweep_wb_regs #(.BASE_ADDRESS(BASE_ADDRESS)) u_regs (
    .clk        (wb_clk_i),
    .reset_n    (reset_n),
    .cyc        (wbs_cyc_i),
    .stb        (wbs_stb_i),
    .we         (wbs_we_i),
    .adr        (wbs_adr_i),
    .dat_i      (wbs_dat_i),
    .ack        (wbs_ack_o),
    .dat_o      (wbs_dat_o),
    .busy       (busy_q),
    .done       (done_q),
    .aborted    (aborted_q),
    .trial_cnt  (trial_cnt_q),
    .hit_cnt    (hit_cnt_q),
    .alarm_sum  (sum_q),
    .hit_map    (hit_map),
    .start_req  (start_req),
    .abort_req  (abort_req),
    .cfg_settle (cfg_settle),
    .cfg_glen   (cfg_glen),
    .cfg_trials (cfg_trials)
  );

  assign do_start  = start_req & ~abort_req & (state_q == ST_IDLE);
  assign do_abort  = abort_req & (state_q != ST_IDLE);
  assign do_sample = (state_q == ST_SAMPLE) & ~do_abort;

  // cnt_q holds the remaining cycles minus one in the timed states.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
    unique case (state_q)
      ST_IDLE: if (do_start) begin
        if (cfg_trials == 8'd0) state_d = ST_DONE;
        else begin
          state_d = ST_POWER;
          cnt_d   = cfg_settle;
        end
      end
      ST_POWER: if (cnt_q == 8'd0) begin
        state_d = ST_CLEAR;
        cnt_d   = 8'd1;
      end
      ST_CLEAR: if (cnt_q == 8'd0) begin
        state_d = ST_GLITCH;
        cnt_d   = (cfg_glen != 8'd0) ? cfg_glen - 8'd1 : 8'd0;
      end
      ST_GLITCH: if (cnt_q == 8'd0) begin
        if (cfg_settle == 8'd0) state_d = ST_SAMPLE;
        else begin
          state_d = ST_SETTLE;
          cnt_d   = cfg_settle - 8'd1;
        end
      end
      ST_SETTLE: if (cnt_q == 8'd0) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_NEXT;
      ST_NEXT: begin
        if (trial_cnt_q == cfg_trials) state_d = ST_DONE;
        else begin
          state_d = ST_CLEAR;
          cnt_d   = 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (do_abort) state_d = ST_IDLE;
  end

  always_comb begin
    trial_cnt_d = trial_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    sum_d       = sum_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    if (do_start) begin
      trial_cnt_d = '0;
      hit_cnt_d   = '0;
      sum_d       = '0;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
    end
    if (do_sample) begin
      trial_cnt_d = trial_cnt_q + 8'd1;
      if (hp_alarm_latch && hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
      sum_d = sat_add16(sum_q, hp_alarm_ctr);
    end
    if (state_d == ST_DONE) done_d = 1'b1;
    if (do_abort) aborted_d = 1'b1;

    vcc_d    = (state_d inside {ST_POWER, ST_CLEAR, ST_GLITCH, ST_SETTLE, ST_SAMPLE, ST_NEXT});
    rst_d    = (state_d == ST_CLEAR);
    glitch_d = (state_d == ST_GLITCH);
    irq_d    = (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      trial_cnt_q <= '0;
      hit_cnt_q   <= '0;
      sum_q       <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      vcc_q       <= 1'b0;
      rst_q       <= 1'b0;
      glitch_q    <= 1'b0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trial_cnt_q <= trial_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      vcc_q       <= vcc_d;
      rst_q       <= rst_d;
      glitch_q    <= glitch_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
    end
  end

`ifdef HP_SWEEP_HITMAP_EN
  logic [31:0] hit_map_q, hit_map_d;

  always_comb begin
    hit_map_d = hit_map_q;
    if (do_start) hit_map_d = '0;
    if (do_sample && hp_alarm_latch && trial_cnt_q < 8'd32) hit_map_d[trial_cnt_q[4:0]] = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) hit_map_q <= '0;
    else          hit_map_q <= hit_map_d;
  end

  assign hit_map = hit_map_q;
`else
  assign hit_map = 32'd0;
`endif

  assign wbs_stl_o        = 1'b0;
  assign hp_vcc           = vcc_q;
  assign hp_alarm_rst     = rst_q;
  assign hp_alarm_ctr_rst = rst_q;
  assign hp_glitch_en     = glitch_q;
  assign irq              = irq_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_hp_sweep_ctrl.sv
// Self-checking bench for hp_sweep_ctrl: per-cycle output trace and final register
// values predicted from a phase-list model of the trial loop.
`timescale 1ns/1ps
module tb_hp_sweep_ctrl;

  localparam logic [31:0] BASE     = 32'h3000_0100;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_CFG    = BASE + 32'h04;
  localparam logic [31:0] A_STATUS = BASE + 32'h08;
  localparam logic [31:0] A_SUM    = BASE + 32'h0C;
  localparam logic [31:0] A_MAP    = BASE + 32'h10;

  logic        wb_clk_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o, wbs_stl_o;
  logic [31:0] wbs_dat_o;
  logic        hp_alarm_latch = 1'b0;
  logic [7:0]  hp_alarm_ctr = '0;
  logic        hp_vcc, hp_alarm_rst, hp_alarm_ctr_rst, hp_glitch_en, busy, irq;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Model trace: one entry per cycle, {irq, glitch, clear, vcc}.
  logic [3:0] exp_q[$];
  int         trial_q[$];
  bit         smp_q[$];
  bit         hit_pat[256];
  logic [7:0] ctr_pat[256];
  logic [31:0] rd_data;

  hp_sweep_ctrl #(.BASE_ADDRESS(BASE)) dut (
    .wb_clk_i         (wb_clk_i),
    .reset_n          (reset_n),
    .wbs_cyc_i        (wbs_cyc_i),
    .wbs_stb_i        (wbs_stb_i),
    .wbs_we_i         (wbs_we_i),
    .wbs_adr_i        (wbs_adr_i),
    .wbs_dat_i        (wbs_dat_i),
    .wbs_ack_o        (wbs_ack_o),
    .wbs_stl_o        (wbs_stl_o),
    .wbs_dat_o        (wbs_dat_o),
    .hp_alarm_latch   (hp_alarm_latch),
    .hp_alarm_ctr     (hp_alarm_ctr),
    .hp_vcc           (hp_vcc),
    .hp_alarm_rst     (hp_alarm_rst),
    .hp_alarm_ctr_rst (hp_alarm_ctr_rst),
    .hp_glitch_en     (hp_glitch_en),
    .busy             (busy),
    .irq              (irq)
  );

  // clock / reset
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

  // driver tasks: each Wishbone access occupies exactly one clock cycle
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input bit exp_ack);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = a;    wbs_dat_i = d;
    @(posedge wb_clk_i); #1;
    check_cnt++;
    if (wbs_ack_o !== exp_ack) $display("FAIL wr_ack @%h: got %b expected %b", a, wbs_ack_o, exp_ack);
    else pass_cnt++;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = a;
    @(posedge wb_clk_i); #1;
    check_cnt++;
    if (wbs_ack_o !== 1'b1) $display("FAIL rd_ack @%h: got %b expected 1", a, wbs_ack_o);
    else pass_cnt++;
    d = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  // Reference model: list the phases of the whole run, one entry per cycle.
  task automatic build_model(input int s, input int g, input int n);
    int gg;
    exp_q.delete(); trial_q.delete(); smp_q.delete();
    gg = (g == 0) ? 1 : g;
    if (n > 0) begin
      for (int c = 0; c < s + 1; c++) begin exp_q.push_back(4'b0001); trial_q.push_back(-1); smp_q.push_back(0); end
      for (int t = 0; t < n; t++) begin
        for (int c = 0; c < 2; c++)  begin exp_q.push_back(4'b0011); trial_q.push_back(t); smp_q.push_back(0); end
        for (int c = 0; c < gg; c++) begin exp_q.push_back(4'b0101); trial_q.push_back(t); smp_q.push_back(0); end
        for (int c = 0; c < s; c++)  begin exp_q.push_back(4'b0001); trial_q.push_back(t); smp_q.push_back(0); end
        exp_q.push_back(4'b0001); trial_q.push_back(t); smp_q.push_back(1);
        exp_q.push_back(4'b0001); trial_q.push_back(t); smp_q.push_back(0);
      end
    end
    exp_q.push_back(4'b1000); trial_q.push_back(-1); smp_q.push_back(0);
    exp_q.push_back(4'b0000); trial_q.push_back(-1); smp_q.push_back(0);
  endtask

  task automatic run_sequence(input string tag, input int s, input int g, input int n,
                              input int abort_at, input int restart_at);
    int          exp_trials, exp_hits, exp_sum, t, last;
    logic [31:0] exp_map, exp_status;
    logic [5:0]  exp_o, obs_o;
    bit          ab;
    exp_trials = 0; exp_hits = 0; exp_sum = 0; exp_map = '0; ab = 0;
    build_model(s, g, n);
    last = exp_q.size() - 1;
    wb_write(A_CFG, (n << 16) | (g << 8) | s, 1'b1);
    wb_write(A_CTRL, 32'h1, 1'b1);
    for (int i = 0; i <= last; i++) begin
      t = trial_q[i];
      if (smp_q[i]) begin
        hp_alarm_latch = hit_pat[t];
        hp_alarm_ctr   = ctr_pat[t];
      end else begin
        hp_alarm_latch = 1'($urandom_range(0, 1));
        hp_alarm_ctr   = 8'($urandom_range(0, 255));
      end
      exp_o = {(i != last), exp_q[i][3], exp_q[i][2], exp_q[i][1], exp_q[i][1], exp_q[i][0]};
      obs_o = {busy, irq, hp_glitch_en, hp_alarm_ctr_rst, hp_alarm_rst, hp_vcc};
      check_cnt++;
      if (obs_o !== exp_o) $display("FAIL %s trace[%0d] {busy,irq,glitch,crst,rst,vcc}: got %b expected %b", tag, i, obs_o, exp_o);
      else pass_cnt++;
      if (i == abort_at) begin
        wb_write(A_CTRL, 32'h2, 1'b1);
        ab = 1;
        for (int k = 0; k < 3; k++) begin
          obs_o = {busy, irq, hp_glitch_en, hp_alarm_ctr_rst, hp_alarm_rst, hp_vcc};
          check_cnt++;
          if (obs_o !== 6'b0) $display("FAIL %s after_abort[%0d]: got %b expected 000000", tag, k, obs_o);
          else pass_cnt++;
          @(posedge wb_clk_i); #1;
        end
        break;
      end
      if (smp_q[i]) begin
        exp_trials++;
        if (hit_pat[t]) begin
          exp_hits++;
          if (t < 32) exp_map[t] = 1'b1;
        end
        exp_sum = exp_sum + int'(ctr_pat[t]);
        if (exp_sum > 65535) exp_sum = 65535;
      end
      if (i == restart_at) wb_write(A_CTRL, 32'h1, 1'b1);
      else begin @(posedge wb_clk_i); #1; end
    end
    if (exp_hits > 255) exp_hits = 255;
`ifndef HP_SWEEP_HITMAP_EN
    exp_map = '0;
`endif
    exp_status = {8'd0, 8'(exp_hits), 8'(exp_trials), 5'd0, ab, !ab, 1'b0};
    wb_read(A_STATUS, rd_data);
    check_cnt++;
    if (rd_data !== exp_status) $display("FAIL %s status: got %h expected %h", tag, rd_data, exp_status);
    else pass_cnt++;
    wb_read(A_SUM, rd_data);
    check_cnt++;
    if (rd_data !== 32'(exp_sum)) $display("FAIL %s alarm_sum: got %h expected %h", tag, rd_data, 32'(exp_sum));
    else pass_cnt++;
    wb_read(A_MAP, rd_data);
    check_cnt++;
    if (rd_data !== exp_map) $display("FAIL %s hit_map: got %h expected %h", tag, rd_data, exp_map);
    else pass_cnt++;
  endtask

  task automatic clear_patterns();
    for (int i = 0; i < 256; i++) begin hit_pat[i] = 0; ctr_pat[i] = 8'd0; end
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset_n = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    obs = {wbs_ack_o, busy, irq, hp_glitch_en, hp_alarm_ctr_rst, hp_alarm_rst, hp_vcc};
    check_cnt++;
    if (obs !== 7'b0 || wbs_stl_o !== 1'b0 || wbs_dat_o !== 32'd0)
      $display("FAIL reset_outputs: got %b stl=%b dat=%h expected all 0", obs, wbs_stl_o, wbs_dat_o);
    else pass_cnt++;
    reset_n = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_read(A_CFG, rd_data);
    check_cnt++;
    if (rd_data !== 32'd0) $display("FAIL reset_cfg: got %h expected 0", rd_data); else pass_cnt++;
    wb_read(A_STATUS, rd_data);
    check_cnt++;
    if (rd_data !== 32'd0) $display("FAIL reset_status: got %h expected 0", rd_data); else pass_cnt++;
    wb_read(A_SUM, rd_data);
    check_cnt++;
    if (rd_data !== 32'd0) $display("FAIL reset_sum: got %h expected 0", rd_data); else pass_cnt++;
  endtask

  task automatic test_regs();
    logic [31:0] v;
    wb_write(A_CFG, 32'hFFFF_FFFF, 1'b1);
    wb_read(A_CFG, rd_data);
    check_cnt++;
    if (rd_data !== 32'h00FF_FFFF) $display("FAIL cfg_mask: got %h expected 00ffffff", rd_data); else pass_cnt++;
    v = $urandom;
    wb_write(A_CFG, v, 1'b1);
    wb_read(A_CFG, rd_data);
    check_cnt++;
    if (rd_data !== {8'd0, v[23:0]}) $display("FAIL cfg_rw: got %h expected %h", rd_data, {8'd0, v[23:0]}); else pass_cnt++;
    wb_write(BASE + 32'h14, 32'h1, 1'b0);
    wb_write(BASE + 32'h100, 32'h1, 1'b0);
    // START|ABORT together from idle must not start
    wb_write(A_CFG, 32'h0001_0101, 1'b1);
    wb_write(A_CTRL, 32'h3, 1'b1);
    check_cnt++;
    if ({busy, hp_vcc, irq} !== 3'b000) $display("FAIL start_abort_same: got %b expected 000", {busy, hp_vcc, irq}); else pass_cnt++;
  endtask

  task automatic test_basic();
    clear_patterns();
    run_sequence("basic", 2, 3, 4, -1, -1);
  endtask

  task automatic test_hits();
    clear_patterns();
    hit_pat[1] = 1; ctr_pat[1] = 8'd5;
    hit_pat[3] = 1; ctr_pat[3] = 8'd5;
    run_sequence("hits", 2, 3, 4, -1, -1);
  endtask

  task automatic test_trials_zero();
    clear_patterns();
    run_sequence("zero", 3, 2, 0, -1, -1);
  endtask

  task automatic test_abort();
    int idx;
    clear_patterns();
    hit_pat[0] = 1; ctr_pat[0] = 8'd7;
    build_model(2, 3, 4);
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && trial_q[i] == 1 && exp_q[i][2]) idx = i;
    run_sequence("abort", 2, 3, 4, idx, -1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin hit_pat[i] = 1; ctr_pat[i] = 8'd255; end
    run_sequence("sat200", 0, 1, 200, -1, -1);
    run_sequence("sat255", 0, 0, 255, -1, -1);
  endtask

  task automatic test_back_to_back();
    clear_patterns();
    hit_pat[0] = 1; ctr_pat[0] = 8'd9; ctr_pat[1] = 8'd4;
    run_sequence("restart_busy", 1, 2, 3, -1, 4);
    run_sequence("b2b", 0, 0, 2, -1, -1);
  endtask

  task automatic test_random();
    int s, g, n, ab, rs;
    for (int r = 0; r < 6; r++) begin
      s = $urandom_range(0, 4);
      g = $urandom_range(0, 4);
      n = $urandom_range(1, 40);
      for (int i = 0; i < 256; i++) begin
        hit_pat[i] = 1'($urandom_range(0, 1));
        ctr_pat[i] = 8'($urandom_range(0, 255));
      end
      build_model(s, g, n);
      ab = (r == 3) ? $urandom_range(0, exp_q.size() - 3) : -1;
      rs = (r == 1) ? $urandom_range(0, exp_q.size() - 3) : -1;
      run_sequence($sformatf("rand%0d", r), s, g, n, ab, rs);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs;
    wb_write(A_CFG, 32'h0003_0105, 1'b1);
    wb_write(A_CTRL, 32'h1, 1'b1);
    @(posedge wb_clk_i); #1;
    check_cnt++;
    if (hp_vcc !== 1'b1) $display("FAIL mid_power_vcc: got %b expected 1", hp_vcc); else pass_cnt++;
    reset_n = 1'b0;
    @(posedge wb_clk_i); #1;
    reset_n = 1'b1;
    obs = {busy, irq, hp_glitch_en, hp_alarm_ctr_rst, hp_alarm_rst, hp_vcc};
    check_cnt++;
    if (obs !== 6'b0) $display("FAIL mid_reset_outputs: got %b expected 000000", obs); else pass_cnt++;
    wb_read(A_CFG, rd_data);
    check_cnt++;
    if (rd_data !== 32'd0) $display("FAIL mid_reset_cfg: got %h expected 0", rd_data); else pass_cnt++;
    wb_read(A_STATUS, rd_data);
    check_cnt++;
    if (rd_data !== 32'd0) $display("FAIL mid_reset_status: got %h expected 0", rd_data); else pass_cnt++;
    wb_write(A_CFG, 32'h000A_0403, 1'b1);
    wb_write(A_CTRL, 32'h1, 1'b1);
    wb_write(A_CFG, 32'h00AB_CDEF, 1'b1);
    wb_read(A_CFG, rd_data);
    check_cnt++;
    if (rd_data !== 32'h000A_0403) $display("FAIL cfg_write_busy: got %h expected 000a0403", rd_data); else pass_cnt++;
    wb_write(A_CTRL, 32'h2, 1'b1);
    check_cnt++;
    if ({busy, hp_vcc} !== 2'b00) $display("FAIL busy_abort: got %b expected 00", {busy, hp_vcc}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic();
    test_hits();
    test_trials_zero();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
